instr_encoder_loader: RTL and testbench

Sequential RV32I instruction encoder and instruction-memory loader. It accepts one instruction description per handshake (instruction class, register indices, funct fields, immediate) and packs it into a 32-bit instruction word. The encoding is the exact inverse of the main decoder's opcode/control mapping. Each encoded word is written to consecutive instruction-memory addresses. It sits in front of the imem write port and is used for self-test program loading and bench stimulus generation.

---
 rtl/instr_encoder_loader.sv | 152 +++++++++++++++
 tb/tb_instr_encoder_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_encoder_loader                                         |
// | Description : Packs RV32I instruction descriptions into 32-bit words and   |
// |               streams them into consecutive instruction-memory addresses.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_encoder_loader #(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_wren,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_full
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [6:0] c_op_lw    = 7'b0000011;
    localparam logic [6:0] c_op_sw    = 7'b0100011;
    localparam logic [6:0] c_op_jal   = 7'b1101111;
    localparam logic [6:0] c_op_jalr  = 7'b1100111;
    localparam logic [6:0] c_op_rtype = 7'b0110011;
    localparam logic [6:0] c_op_btype = 7'b1100011;
    localparam logic [6:0] c_op_itype = 7'b0010011;
    localparam logic [6:0] c_op_lui   = 7'b0110111;
    localparam logic [6:0] c_op_auipc = 7'b0010111;

    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(IMEM_DEPTH);

    logic [1:0]        r_state;
    logic              r_wren;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_err_illegal;
    logic              r_err_full;

    logic              w_accept;
    logic              w_legal;
    logic              w_shift;
    logic [ADDR_W:0]   w_count_nxt;
    logic [31:0]       w_enc;

    assign w_accept    = in_valid && (r_state == c_st_load);
    assign w_legal     = (in_class <= 4'd8);
    assign w_shift     = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    assign w_count_nxt = r_count + 1'b1;

    always_comb begin
        w_enc = 32'h0;
        case (in_class)
            4'd0: w_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, c_op_lw};
            4'd1: w_enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], c_op_sw};
            4'd2: w_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, c_op_jal};
            4'd3: w_enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, c_op_jalr};
            4'd4: w_enc = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, c_op_rtype};
            4'd5: w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], c_op_btype};
            4'd6: begin
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (w_shift) begin
                    w_enc = {1'b0, in_funct7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, c_op_itype};
                end else begin
                    w_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, c_op_itype};
                end
            end
            4'd7: w_enc = {in_imm[31:12], in_rd, c_op_lui};
            4'd8: w_enc = {in_imm[31:12], in_rd, c_op_auipc};
            default: w_enc = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_wren        <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= 32'h0;
            r_count       <= '0;
            r_err_illegal <= 1'b0;
            r_err_full    <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state       <= c_st_load;
                        r_count       <= '0;
                        r_err_illegal <= 1'b0;
                        r_err_full    <= 1'b0;
                    end
                end
                c_st_load: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_wren  <= 1'b1;
                            r_addr  <= r_count[ADDR_W-1:0];
                            r_wdata <= w_enc;
                            r_count <= w_count_nxt;
                            if (in_last) begin
                                r_state <= c_st_done;
                            end else if (w_count_nxt == c_depth) begin
                                r_state    <= c_st_done;
                                r_err_full <= 1'b1;
                            end
                        end else begin
                            r_err_illegal <= 1'b1;
                            if (in_last) begin
                                r_state <= c_st_done;
                            end
                        end
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    assign in_ready    = (r_state == c_st_load);
    assign busy        = (r_state != c_st_idle);
    assign done        = (r_state == c_st_done);
    assign imem_wren   = r_wren;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign count       = r_count;
    assign err_illegal = r_err_illegal;
    assign err_full    = r_err_full;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_encoder_loader                                      |
// | Description : Self-checking bench for instr_encoder_loader (256 and 4 deep)|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset, start_a, start_b, valid_a, valid_b, last;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;

    logic        ready_a, wren_a, busy_a, done_a, ill_a, full_a;
    logic [7:0]  addr_a;
    logic [31:0] wdata_a;
    logic [8:0]  count_a;
    logic        ready_b, wren_b, busy_b, done_b, ill_b, full_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  count_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.IMEM_DEPTH(256), .ADDR_W(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in_valid(valid_a), .in_ready(ready_a),
        .in_last(last), .in_class(cls), .in_funct3(f3), .in_funct7b5(f7), .in_rd(rd),
        .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm), .imem_wren(wren_a), .imem_addr(addr_a),
        .imem_wdata(wdata_a), .count(count_a), .busy(busy_a), .done(done_a),
        .err_illegal(ill_a), .err_full(full_a)
    );

    instr_encoder_loader #(.IMEM_DEPTH(4), .ADDR_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in_valid(valid_b), .in_ready(ready_b),
        .in_last(last), .in_class(cls), .in_funct3(f3), .in_funct7b5(f7), .in_rd(rd),
        .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm), .imem_wren(wren_b), .imem_addr(addr_b),
        .imem_wdata(wdata_b), .count(count_b), .busy(busy_b), .done(done_b),
        .err_illegal(ill_b), .err_full(full_b)
    );

    // Reference encoder: assembles the word field by field with shifts and masks.
    function automatic logic [31:0] model(input int unsigned c, input int unsigned fn3,
                                          input int unsigned fn7, input int unsigned d,
                                          input int unsigned s1, input int unsigned s2,
                                          input logic [31:0] im);
        int unsigned op[9] = '{32'h03, 32'h23, 32'h6F, 32'h67, 32'h33, 32'h63, 32'h13, 32'h37, 32'h17};
        int unsigned u = im;
        int unsigned w;
        w = op[c];
        case (c)
            0, 3: w = w | (d << 7) | ((c == 3 ? 0 : fn3) << 12) | (s1 << 15) | ((u & 32'hFFF) << 20);
            1: w = w | ((u & 31) << 7) | (fn3 << 12) | (s1 << 15) | (s2 << 20) | (((u >> 5) & 127) << 25);
            2: w = w | (d << 7) | (u & 32'h000FF000) | (((u >> 11) & 1) << 20)
                   | (((u >> 1) & 32'h3FF) << 21) | (((u >> 20) & 1) << 31);
            4: w = w | (d << 7) | (fn3 << 12) | (s1 << 15) | (s2 << 20) | (fn7 << 30);
            5: w = w | (((u >> 11) & 1) << 7) | (((u >> 1) & 15) << 8) | (fn3 << 12) | (s1 << 15)
                   | (s2 << 20) | (((u >> 5) & 63) << 25) | (((u >> 12) & 1) << 31);
            6: begin
                if (fn3 == 1 || fn3 == 5)
                    w = w | (d << 7) | (fn3 << 12) | (s1 << 15) | ((u & 31) << 20) | (fn7 << 30);
                else
                    w = w | (d << 7) | (fn3 << 12) | (s1 << 15) | ((u & 32'hFFF) << 20);
            end
            default: w = w | (d << 7) | (u & 32'hFFFFF000);
        endcase
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [3:0] c, input logic [2:0] fn3, input logic fn7,
                              input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [31:0] im, input logic l);
        cls = c; f3 = fn3; f7 = fn7; rd = d; rs1 = s1; rs2 = s2; imm = im; last = l;
    endtask

    task automatic randomize_fields();
        f3 = 3'($urandom); f7 = 1'($urandom); rd = 5'($urandom);
        rs1 = 5'($urandom); rs2 = 5'($urandom); imm = $urandom;
    endtask

    task automatic start_session_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start_a = 0; start_b = 0; valid_a = 0; valid_b = 0;
        set_fields(0, 0, 0, 0, 0, 0, 0, 0);
        step(); step();
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_a); end
        checks++; if (wren_a !== 1'b0) begin errors++; $display("FAIL reset_wren got=%b exp=0", wren_a); end
        checks++; if (addr_a !== 8'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", addr_a); end
        checks++; if (wdata_a !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", wdata_a); end
        checks++; if (count_a !== 9'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_a); end
        checks++; if ({busy_a, done_a, ill_a, full_a} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000", {busy_a, done_a, ill_a, full_a}); end
        checks++; if ({ready_b, busy_b, full_b} !== 3'b0) begin
            errors++; $display("FAIL reset_b got=%b exp=000", {ready_b, busy_b, full_b}); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_addi();
        start_session_a();
        checks++; if ({ready_a, busy_a} !== 2'b11) begin
            errors++; $display("FAIL start_ready_busy got=%b exp=11", {ready_a, busy_a}); end
        set_fields(6, 0, 0, 1, 0, 0, 32'd5, 1); valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        checks++; if (wdata_a !== 32'h00500093) begin errors++; $display("FAIL addi_wdata got=%h exp=00500093", wdata_a); end
        checks++; if ({wren_a, addr_a} !== {1'b1, 8'd0}) begin
            errors++; $display("FAIL addi_write got=%b/%0d exp=1/0", wren_a, addr_a); end
        checks++; if ({done_a, busy_a, count_a} !== {2'b11, 9'd1}) begin
            errors++; $display("FAIL addi_done got=%b%b/%0d exp=11/1", done_a, busy_a, count_a); end
        step();
        checks++; if ({done_a, busy_a, wren_a} !== 3'b000) begin
            errors++; $display("FAIL addi_idle got=%b exp=000", {done_a, busy_a, wren_a}); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  vc[6] = '{4'd0, 4'd1, 4'd5, 4'd2, 4'd7, 4'd4};
        logic [2:0]  vf[6] = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
        logic [4:0]  vd[6] = '{5'd2, 5'd0, 5'd0, 5'd1, 5'd5, 5'd3};
        logic [4:0]  v1[6] = '{5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd1};
        logic [4:0]  v2[6] = '{5'd0, 5'd2, 5'd2, 5'd0, 5'd0, 5'd2};
        logic [31:0] vi[6] = '{32'd8, 32'd4, 32'hFFFFFFFC, 32'd8, 32'h12345000, 32'd0};
        logic [31:0] ve[6] = '{32'h0080A103, 32'h0020A223, 32'hFE208EE3, 32'h008000EF, 32'h123452B7, 32'h402081B3};
        start_session_a();
        for (int i = 0; i < 6; i++) begin
            set_fields(vc[i], vf[i], (i == 5), vd[i], v1[i], v2[i], vi[i], (i == 5));
            valid_a = 1'b1;
            step();
            checks++; if ({wren_a, addr_a, wdata_a} !== {1'b1, 8'(i), ve[i]}) begin
                errors++; $display("FAIL b2b_beat%0d got=%b/%0d/%h exp=1/%0d/%h", i, wren_a, addr_a, wdata_a, i, ve[i]); end
            checks++; if (done_a !== (i == 5)) begin
                errors++; $display("FAIL b2b_done%0d got=%b exp=%b", i, done_a, (i == 5)); end
        end
        valid_a = 1'b0;
        step();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", busy_a); end
    endtask

    task automatic test_illegal();
        start_session_a();
        set_fields(0, 2, 0, 4, 3, 0, 32'd12, 0); valid_a = 1'b1;
        step();
        checks++; if ({wren_a, addr_a, wdata_a} !== {1'b1, 8'd0, model(0, 2, 0, 4, 3, 0, 32'd12)}) begin
            errors++; $display("FAIL ill_first got=%b/%0d/%h", wren_a, addr_a, wdata_a); end
        set_fields(12, 1, 1, 7, 7, 7, 32'd99, 0);
        step();
        checks++; if ({wren_a, count_a} !== {1'b0, 9'd1}) begin
            errors++; $display("FAIL ill_nowrite got=%b/%0d exp=0/1", wren_a, count_a); end
        set_fields(7, 0, 0, 9, 0, 0, 32'hABCDE000, 1);
        step();
        valid_a = 1'b0;
        checks++; if ({wren_a, addr_a, wdata_a, done_a} !== {1'b1, 8'd1, 32'hABCDE4B7, 1'b1}) begin
            errors++; $display("FAIL ill_second got=%b/%0d/%h/%b exp=1/1/abcde4b7/1", wren_a, addr_a, wdata_a, done_a); end
        step();
        checks++; if ({ill_a, busy_a, full_a} !== 3'b100) begin
            errors++; $display("FAIL ill_sticky got=%b exp=100", {ill_a, busy_a, full_a}); end
    endtask

    task automatic test_full();
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            randomize_fields();
            cls = 4'd6; last = 1'b0; valid_b = 1'b1;
            step();
            if (i < 4) begin
                checks++; if ({wren_b, addr_b, wdata_b} !== {1'b1, 2'(i), model(6, f3, f7, rd, rs1, rs2, imm)}) begin
                    errors++; $display("FAIL full_write%0d got=%b/%0d/%h", i, wren_b, addr_b, wdata_b); end
                checks++; if ({done_b, full_b, ready_b} !== ((i == 3) ? 3'b110 : 3'b001)) begin
                    errors++; $display("FAIL full_state%0d got=%b", i, {done_b, full_b, ready_b}); end
            end else begin
                checks++; if ({wren_b, busy_b, count_b, full_b} !== {2'b00, 3'd4, 1'b1}) begin
                    errors++; $display("FAIL full_after got=%b%b/%0d/%b exp=00/4/1", wren_b, busy_b, count_b, full_b); end
            end
        end
        valid_b = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        start_session_a();
        checks++; if (ill_a !== 1'b0) begin errors++; $display("FAIL start_clears_err got=%b exp=0", ill_a); end
        for (int i = 0; i < 2; i++) begin
            randomize_fields(); cls = 4'd4; last = 1'b0; valid_a = 1'b1;
            step();
        end
        checks++; if (count_a !== 9'd2) begin errors++; $display("FAIL mid_count got=%0d exp=2", count_a); end
        reset = 1'b1;
        step();
        reset = 1'b0; valid_a = 1'b0;
        checks++; if ({ready_a, wren_a, addr_a, wdata_a, count_a, busy_a, done_a, ill_a, full_a} !== '0) begin
            errors++; $display("FAIL mid_reset got=%b%b/%0d/%h/%0d/%b%b%b%b exp=all 0", ready_a, wren_a, addr_a,
                               wdata_a, count_a, busy_a, done_a, ill_a, full_a); end
        start_session_a();
        set_fields(8, 0, 0, 3, 0, 0, 32'h00001000, 1); valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        checks++; if ({wren_a, addr_a, wdata_a, count_a} !== {1'b1, 8'd0, 32'h00001197, 9'd1}) begin
            errors++; $display("FAIL mid_restart got=%b/%0d/%h/%0d exp=1/0/00001197/1", wren_a, addr_a, wdata_a, count_a); end
        step();
    endtask

    task automatic test_start_ignored();
        start_session_a();
        randomize_fields(); cls = 4'd3; last = 1'b0; valid_a = 1'b1;
        step();
        randomize_fields(); cls = 4'd1; start_a = 1'b1;
        step();
        start_a = 1'b0;
        checks++; if ({addr_a, count_a, busy_a} !== {8'd1, 9'd2, 1'b1}) begin
            errors++; $display("FAIL restart_ignored got=%0d/%0d/%b exp=1/2/1", addr_a, count_a, busy_a); end
        last = 1'b1;
        step();
        valid_a = 1'b0;
        checks++; if ({addr_a, count_a, done_a} !== {8'd2, 9'd3, 1'b1}) begin
            errors++; $display("FAIL restart_tail got=%0d/%0d/%b exp=2/3/1", addr_a, count_a, done_a); end
        step();
    endtask

    task automatic test_random();
        for (int s = 0; s < 25; s++) begin
            int n = $urandom_range(1, 12);
            int acc = 0;
            int exp_cnt = 0;
            int guard = 0;
            start_session_a();
            while (acc < n && guard < 200) begin
                logic lg;
                logic [31:0] ew;
                guard++;
                valid_a = ($urandom % 4) != 0;
                randomize_fields();
                cls = (($urandom % 8) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
                last = (acc == n - 1);
                lg = (cls < 9);
                ew = lg ? model(cls, f3, f7, rd, rs1, rs2, imm) : 32'h0;
                step();
                if (valid_a) begin
                    acc++;
                    if (lg) exp_cnt++;
                end
                checks++; if (wren_a !== (valid_a && lg)) begin
                    errors++; $display("FAIL rnd_wren s%0d got=%b exp=%b", s, wren_a, valid_a && lg); end
                if (valid_a && lg) begin
                    checks++; if ({addr_a, wdata_a} !== {8'(exp_cnt - 1), ew}) begin
                        errors++; $display("FAIL rnd_word s%0d cls=%0d got=%0d/%h exp=%0d/%h", s, cls, addr_a, wdata_a,
                                           exp_cnt - 1, ew); end
                end
                checks++; if ({count_a, done_a} !== {9'(exp_cnt), valid_a && last}) begin
                    errors++; $display("FAIL rnd_count s%0d got=%0d/%b exp=%0d/%b", s, count_a, done_a, exp_cnt, valid_a && last); end
            end
            checks++; if (acc != n) begin errors++; $display("FAIL rnd_budget s%0d got=%0d exp=%0d", s, acc, n); end
            valid_a = 1'b0;
            step();
            checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rnd_idle s%0d got=%b exp=0", s, busy_a); end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_illegal();
        test_full();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
